// File: rtl/pic_pkg.sv
// Shared types, control-word indices and helper functions for the PIC control sequencer.
package pic_pkg;

  localparam int MAX_IRQ = 16;

  typedef enum logic [2:0] {
    I_ICW1,
    I_ICW2,
    I_ICW3,
    I_ICW4,
    I_READY
  } init_state_e;

  typedef enum logic [1:0] {
    A_IDLE,
    A_ACK1,
    A_ACK2
  } ack_state_e;

  localparam logic [2:0] CW_ICW1 = 3'd0;
  localparam logic [2:0] CW_ICW2 = 3'd1;
  localparam logic [2:0] CW_ICW3 = 3'd2;
  localparam logic [2:0] CW_ICW4 = 3'd3;
  localparam logic [2:0] CW_OCW1 = 3'd4;
  localparam logic [2:0] CW_OCW2 = 3'd5;
  localparam logic [2:0] CW_OCW3 = 3'd6;

  localparam logic [2:0] OCW2_NS_EOI     = 3'b001;
  localparam logic [2:0] OCW2_SP_EOI     = 3'b011;
  localparam logic [2:0] OCW2_ROT_NS_EOI = 3'b101;
  localparam logic [2:0] OCW2_ROT_SP_EOI = 3'b111;
  localparam logic [2:0] OCW2_SET_PRIO   = 3'b110;
  localparam logic [2:0] OCW2_AROT_SET   = 3'b100;
  localparam logic [2:0] OCW2_AROT_CLR   = 3'b000;

  localparam logic [1:0] RD_IRR = 2'd0;
  localparam logic [1:0] RD_ISR = 2'd1;
  localparam logic [1:0] RD_IMR = 2'd2;

  function automatic logic [MAX_IRQ-1:0] onehot(input logic [3:0] id);
    logic [MAX_IRQ-1:0] r;
    r     = '0;
    r[id] = 1'b1;
    return r;
  endfunction

  // Returns {found, id}; priority starts just above 'lowest' and wraps modulo n.
  function automatic logic [4:0] rotated_highest(input logic [MAX_IRQ-1:0] v,
                                                 input logic [3:0] lowest,
                                                 input int n);
    logic [4:0] r;
    int idx;
    r = '0;
    for (int k = n - 1; k >= 0; k--) begin
      idx = (int'(lowest) + 1 + k) % n;
      if (v[idx]) r = {1'b1, 4'(idx)};
    end
    return r;
  endfunction

endpackage

// File: rtl/pic_ack_fsm.sv
// Two-pulse INTA acknowledge sequencer: edge detect, ID latch, vector drive and freeze.
module pic_ack_fsm
  import pic_pkg::*;
#(
  parameter int NUM_IRQ = 8,
  parameter int ID_W    = $clog2(NUM_IRQ)
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                abort_i,
  input  logic                enable_i,
  input  logic                inta_n_i,
  input  logic                req_valid_i,
  input  logic [ID_W-1:0]     req_id_i,
  input  logic [7-ID_W:0]     base_i,
  output logic                int_o,
  output logic [7:0]          vector_o,
  output logic                vector_oe_o,
  output logic                freeze_o,
  output logic [NUM_IRQ-1:0]  isr_set_o,
  output logic                ack_done_o,
  output logic [ID_W-1:0]     ack_id_o
);

  ack_state_e state_q, state_d;
  logic               inta_q;
  logic [ID_W-1:0]    id_q, id_d;
  logic [7:0]         vec_q, vec_d;
  logic               int_q, int_d;
  logic               oe_q, oe_d;
  logic               frz_q, frz_d;
  logic [NUM_IRQ-1:0] set_q, set_d;
  logic               fall, rise;

  function automatic logic [NUM_IRQ-1:0] onehot_n(input logic [ID_W-1:0] id);
    logic [MAX_IRQ-1:0] full;
    full = onehot(4'(id));
    return full[NUM_IRQ-1:0];
  endfunction

  assign fall = inta_q & ~inta_n_i;
  assign rise = ~inta_q & inta_n_i;

  always_comb begin
    state_d    = state_q;
    id_d       = id_q;
    vec_d      = vec_q;
    set_d      = '0;
    ack_done_o = 1'b0;
    if (abort_i) begin
      state_d = A_IDLE;
    end else begin
      case (state_q)
        A_IDLE: if (fall && enable_i) begin
          state_d = A_ACK1;
          id_d    = req_valid_i ? req_id_i : ID_W'(NUM_IRQ - 1);
          if (req_valid_i) set_d = onehot_n(req_id_i);
        end
        A_ACK1: if (fall) begin
          state_d = A_ACK2;
          vec_d   = {base_i, id_q};
        end
        A_ACK2: if (rise) begin
          state_d    = A_IDLE;
          ack_done_o = 1'b1;
        end
        default: state_d = A_IDLE;
      endcase
    end
    frz_d = (state_d != A_IDLE);
    oe_d  = (state_d == A_ACK2) && !inta_n_i;
    case (state_d)
      A_IDLE:  int_d = req_valid_i && enable_i && !abort_i;
      A_ACK1:  int_d = 1'b1;
      default: int_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= A_IDLE;
      inta_q  <= 1'b1;
      id_q    <= '0;
      vec_q   <= '0;
      int_q   <= 1'b0;
      oe_q    <= 1'b0;
      frz_q   <= 1'b0;
      set_q   <= '0;
    end else begin
      state_q <= state_d;
      inta_q  <= inta_n_i;
      id_q    <= id_d;
      vec_q   <= vec_d;
      int_q   <= int_d;
      oe_q    <= oe_d;
      frz_q   <= frz_d;
      set_q   <= set_d;
    end
  end

  assign int_o       = int_q;
  assign vector_o    = vec_q;
  assign vector_oe_o = oe_q;
  assign freeze_o    = frz_q;
  assign isr_set_o   = set_q;
  assign ack_id_o    = id_q;

endmodule

// File: rtl/pic_ctrl_seq.sv
// PIC control sequencer: ICW init, OCW decode, EOI/rotation and read-back.
// Define SPECIAL_MASK_EN to enable OCW3 special-mask mode.
module pic_ctrl_seq
  import pic_pkg::*;
#(
  parameter int NUM_IRQ = 8,
  parameter int ID_W    = $clog2(NUM_IRQ)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               cw_wr,
  input  logic [2:0]         cw_sel,
  input  logic [NUM_IRQ-1:0] cw_data,
  input  logic [1:0]         rd_sel,
  input  logic [NUM_IRQ-1:0] irr,
  input  logic [NUM_IRQ-1:0] isr,
  input  logic               req_valid,
  input  logic [ID_W-1:0]    req_id,
  input  logic               inta_n,
  output logic               int_o,
  output logic [NUM_IRQ-1:0] rd_data,
  output logic [7:0]         vector,
  output logic               vector_oe,
  output logic [NUM_IRQ-1:0] imr,
  output logic [NUM_IRQ-1:0] special_mask,
  output logic [NUM_IRQ-1:0] isr_set,
  output logic [NUM_IRQ-1:0] eoi_clr,
  output logic [ID_W-1:0]    prio_rotate,
  output logic               freeze,
  output logic               init_done
);

  localparam int BASE_W = 8 - ID_W;

  init_state_e init_q, init_d;
  logic               sngl_q, sngl_d, ic4_q, ic4_d;
  logic               aeoi_q, aeoi_d, arot_q, arot_d;
  logic [BASE_W-1:0]  base_q, base_d;
  logic [NUM_IRQ-1:0] imr_q, imr_d, eoi_q, eoi_d, rd_q, rd_d;
  logic [ID_W-1:0]    prio_q, prio_d;
  logic [NUM_IRQ-1:0] isr_ns;
  logic               icw1_wr, ack_done;
  logic [ID_W-1:0]    ack_id, lvl, hi_id;
  logic [2:0]         cmd;
  logic               hi_found;

`ifdef SPECIAL_MASK_EN
  logic               smm_q, smm_d;
  logic [NUM_IRQ-1:0] sm_q, sm_d;
  assign isr_ns       = isr & ~sm_q;
  assign special_mask = sm_q;
`else
  assign isr_ns       = isr;
  assign special_mask = '0;
`endif

  function automatic logic [NUM_IRQ-1:0] onehot_n(input logic [ID_W-1:0] id);
    logic [MAX_IRQ-1:0] full;
    full = onehot(4'(id));
    return full[NUM_IRQ-1:0];
  endfunction

  function automatic logic [ID_W:0] highest_n(input logic [NUM_IRQ-1:0] v,
                                              input logic [ID_W-1:0] low);
    logic [4:0] r;
    r = rotated_highest(16'(v), 4'(low), NUM_IRQ);
    return {r[4], r[ID_W-1:0]};
  endfunction

  assign icw1_wr = cw_wr && (cw_sel == CW_ICW1);
  assign cmd     = cw_data[7:5];
  assign lvl     = cw_data[ID_W-1:0];
  assign {hi_found, hi_id} = highest_n(isr_ns, prio_q);

  pic_ack_fsm #(.NUM_IRQ(NUM_IRQ), .ID_W(ID_W)) u_ack (
    .clk         (clk),
    .reset_n     (reset_n),
    .abort_i     (icw1_wr),
    .enable_i    (init_done),
    .inta_n_i    (inta_n),
    .req_valid_i (req_valid),
    .req_id_i    (req_id),
    .base_i      (base_q),
    .int_o       (int_o),
    .vector_o    (vector),
    .vector_oe_o (vector_oe),
    .freeze_o    (freeze),
    .isr_set_o   (isr_set),
    .ack_done_o  (ack_done),
    .ack_id_o    (ack_id)
  );

  // Init sequencing and OCW decode; an ICW1 write overrides everything else.
  always_comb begin
    init_d = init_q;
    sngl_d = sngl_q;
    ic4_d  = ic4_q;
    aeoi_d = aeoi_q;
    arot_d = arot_q;
    base_d = base_q;
    imr_d  = imr_q;
    prio_d = prio_q;
    eoi_d  = '0;
`ifdef SPECIAL_MASK_EN
    smm_d  = smm_q;
    sm_d   = sm_q;
`endif
    if (ack_done && aeoi_q) begin
      eoi_d = onehot_n(ack_id);
      if (arot_q) prio_d = ack_id;
    end
    if (icw1_wr) begin
      init_d = I_ICW2;
      sngl_d = cw_data[1];
      ic4_d  = cw_data[0];
      aeoi_d = 1'b0;
      arot_d = 1'b0;
      imr_d  = '1;
      prio_d = ID_W'(NUM_IRQ - 1);
    end else if (cw_wr) begin
      case (init_q)
        I_ICW2: if (cw_sel == CW_ICW2) begin
          base_d = cw_data[7:ID_W];
          if (!sngl_q)     init_d = I_ICW3;
          else if (ic4_q)  init_d = I_ICW4;
          else             init_d = I_READY;
        end
        I_ICW3: if (cw_sel == CW_ICW3) init_d = ic4_q ? I_ICW4 : I_READY;
        I_ICW4: if (cw_sel == CW_ICW4) begin
          aeoi_d = cw_data[1];
          init_d = I_READY;
        end
        I_READY: begin
          case (cw_sel)
            CW_OCW1: begin
`ifdef SPECIAL_MASK_EN
              if (smm_q) sm_d = cw_data;
              else       imr_d = cw_data;
`else
              imr_d = cw_data;
`endif
            end
            CW_OCW2: begin
              case (cmd)
                OCW2_NS_EOI: if (hi_found) eoi_d = onehot_n(hi_id);
                OCW2_SP_EOI: if (|isr) eoi_d = onehot_n(lvl);
                OCW2_ROT_NS_EOI: if (hi_found) begin
                  eoi_d  = onehot_n(hi_id);
                  prio_d = hi_id;
                end
                OCW2_ROT_SP_EOI: begin
                  if (|isr) eoi_d = onehot_n(lvl);
                  prio_d = lvl;
                end
                OCW2_SET_PRIO: prio_d = lvl;
                OCW2_AROT_SET: arot_d = 1'b1;
                OCW2_AROT_CLR: arot_d = 1'b0;
                default: ;
              endcase
            end
`ifdef SPECIAL_MASK_EN
            CW_OCW3: begin
              if (cw_data[6:5] == 2'b11) smm_d = 1'b1;
              else if (cw_data[6:5] == 2'b10) begin
                smm_d = 1'b0;
                sm_d  = '0;
              end
            end
`endif
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    case (rd_sel)
      RD_IRR:  rd_d = irr;
      RD_ISR:  rd_d = isr;
      RD_IMR:  rd_d = imr_q;
      default: rd_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      init_q <= I_ICW1;
      sngl_q <= 1'b0;
      ic4_q  <= 1'b0;
      aeoi_q <= 1'b0;
      arot_q <= 1'b0;
      base_q <= '0;
      imr_q  <= '1;
      eoi_q  <= '0;
      prio_q <= ID_W'(NUM_IRQ - 1);
      rd_q   <= '0;
    end else begin
      init_q <= init_d;
      sngl_q <= sngl_d;
      ic4_q  <= ic4_d;
      aeoi_q <= aeoi_d;
      arot_q <= arot_d;
      base_q <= base_d;
      imr_q  <= imr_d;
      eoi_q  <= eoi_d;
      prio_q <= prio_d;
      rd_q   <= rd_d;
    end
  end

`ifdef SPECIAL_MASK_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      smm_q <= 1'b0;
      sm_q  <= '0;
    end else begin
      smm_q <= smm_d;
      sm_q  <= sm_d;
    end
  end
`endif

  assign init_done   = (init_q == I_READY);
  assign imr         = imr_q;
  assign eoi_clr     = eoi_q;
  assign prio_rotate = prio_q;
  assign rd_data     = rd_q;

endmodule

// File: tb/tb_pic_ctrl_seq.sv
// Scoreboard bench for pic_ctrl_seq: 8-line and 16-line instances, pulse outputs checked by a monitor.
module tb_pic_ctrl_seq;

  localparam logic [1:0] K_ISR = 2'd0;
  localparam logic [1:0] K_EOI = 2'd1;
  localparam logic [1:0] K_VEC = 2'd2;

  typedef struct {
    logic [1:0]  kind;
    logic [15:0] val;
  } exp_t;

  exp_t expQ[$];
  int   vectors = 0;
  int   miscompares = 0;

  logic        clk = 1'b0;
  logic        resetN;
  logic        cwWr8, cwWr16;
  logic [2:0]  cwSel;
  logic [15:0] cwData;
  logic [1:0]  rdSel;
  logic [15:0] irr, isr;
  logic        reqValid;
  logic [3:0]  reqId;
  logic        intaN8, intaN16;

  logic       int8, vecOe8, freeze8, done8;
  logic [7:0] rdData8, vector8, imr8, sm8, isrSet8, eoiClr8;
  logic [2:0] prio8;

  logic        int16, vecOe16, freeze16, done16;
  logic [15:0] rdData16, imr16, sm16, isrSet16, eoiClr16;
  logic [7:0]  vector16;
  logic [3:0]  prio16;

  always #5 clk = ~clk;

  pic_ctrl_seq #(.NUM_IRQ(8)) dut8 (
    .clk(clk), .reset_n(resetN), .cw_wr(cwWr8), .cw_sel(cwSel), .cw_data(cwData[7:0]),
    .rd_sel(rdSel), .irr(irr[7:0]), .isr(isr[7:0]), .req_valid(reqValid), .req_id(reqId[2:0]),
    .inta_n(intaN8), .int_o(int8), .rd_data(rdData8), .vector(vector8), .vector_oe(vecOe8),
    .imr(imr8), .special_mask(sm8), .isr_set(isrSet8), .eoi_clr(eoiClr8),
    .prio_rotate(prio8), .freeze(freeze8), .init_done(done8)
  );

  pic_ctrl_seq #(.NUM_IRQ(16)) dut16 (
    .clk(clk), .reset_n(resetN), .cw_wr(cwWr16), .cw_sel(cwSel), .cw_data(cwData),
    .rd_sel(rdSel), .irr(irr), .isr(isr), .req_valid(reqValid), .req_id(reqId),
    .inta_n(intaN16), .int_o(int16), .rd_data(rdData16), .vector(vector16), .vector_oe(vecOe16),
    .imr(imr16), .special_mask(sm16), .isr_set(isrSet16), .eoi_clr(eoiClr16),
    .prio_rotate(prio16), .freeze(freeze16), .init_done(done16)
  );

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic popCompare(input string name, input logic [1:0] kind, input logic [15:0] act);
    exp_t e;
    vectors++;
    if (expQ.size() == 0) begin
      miscompares++;
      $display("[TB] FAIL %s: unexpected output %h, nothing expected", name, act);
    end else begin
      e = expQ.pop_front();
      if (e.kind !== kind || e.val !== act) begin
        miscompares++;
        $display("[TB] FAIL %s: got kind %0d value %h, expected kind %0d value %h",
                 name, kind, act, e.kind, e.val);
      end
    end
  endtask

  // Monitor: every pulse or vector presented by the 8-line instance is checked against the queue.
  logic oePrev = 1'b0;
  initial begin
    forever begin
      @(negedge clk);
      if (resetN === 1'b1) begin
        if (isrSet8 !== 8'h00) popCompare("isr_set", K_ISR, 16'(isrSet8));
        if (eoiClr8 !== 8'h00) popCompare("eoi_clr", K_EOI, 16'(eoiClr8));
        if (vecOe8 === 1'b1 && oePrev === 1'b0) popCompare("vector", K_VEC, 16'(vector8));
      end
      oePrev = vecOe8;
    end
  end

  task automatic expectEvent(input logic [1:0] kind, input logic [15:0] val);
    exp_t e;
    e.kind = kind;
    e.val  = val;
    expQ.push_back(e);
  endtask

  task automatic applyStimulus(input bit wide, input logic [2:0] sel, input logic [15:0] data);
    cwSel  = sel;
    cwData = data;
    if (wide) cwWr16 = 1'b1;
    else      cwWr8  = 1'b1;
    @(negedge clk);
    cwWr8  = 1'b0;
    cwWr16 = 1'b0;
  endtask

  task automatic intaSet(input bit wide, input logic level);
    if (wide) intaN16 = level;
    else      intaN8  = level;
    @(negedge clk);
  endtask

  task automatic initSingle(input bit wide, input logic [7:0] icw2, input logic [7:0] icw4);
    applyStimulus(wide, 3'd0, 16'h0013);
    applyStimulus(wide, 3'd1, 16'(icw2));
    applyStimulus(wide, 3'd3, 16'(icw4));
  endtask

  initial begin
    resetN = 1'b0; cwWr8 = 1'b0; cwWr16 = 1'b0; cwSel = '0; cwData = '0; rdSel = 2'd0;
    irr = '0; isr = '0; reqValid = 1'b0; reqId = '0; intaN8 = 1'b1; intaN16 = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("reset int_o", 16'(int8), 16'h0);
    checkOutput("reset imr", 16'(imr8), 16'h00FF);
    checkOutput("reset prio8", 16'(prio8), 16'h0007);
    checkOutput("reset prio16", 16'(prio16), 16'h000F);
    checkOutput("reset init_done", 16'(done8), 16'h0);
    checkOutput("reset vector_oe", 16'(vecOe8), 16'h0);
    checkOutput("reset freeze", 16'(freeze8), 16'h0);
    checkOutput("reset special_mask", 16'(sm8), 16'h0);
    resetN = 1'b1;
    @(negedge clk);

    $display("[TB] init single mode with IC4");
    applyStimulus(0, 3'd0, 16'h0013);
    applyStimulus(0, 3'd1, 16'h0040);
    checkOutput("init_done before ICW4", 16'(done8), 16'h0);
    applyStimulus(0, 3'd3, 16'h0001);
    checkOutput("init_done after ICW4", 16'(done8), 16'h1);
    checkOutput("imr after init", 16'(imr8), 16'h00FF);

    $display("[TB] full acknowledge id 3");
    applyStimulus(0, 3'd4, 16'h0000);
    checkOutput("imr after OCW1", 16'(imr8), 16'h0000);
    reqValid = 1'b1; reqId = 4'd3;
    @(negedge clk);
    checkOutput("int_o request", 16'(int8), 16'h1);
    expectEvent(K_ISR, 16'h0008);
    intaSet(0, 1'b0);
    intaSet(0, 1'b1);
    checkOutput("freeze between pulses", 16'(freeze8), 16'h1);
    checkOutput("int_o held in ACK1", 16'(int8), 16'h1);
    expectEvent(K_VEC, 16'h0043);
    intaSet(0, 1'b0);
    checkOutput("int_o at second pulse", 16'(int8), 16'h0);
    checkOutput("vector_oe second pulse", 16'(vecOe8), 16'h1);
    checkOutput("freeze second pulse", 16'(freeze8), 16'h1);
    intaSet(0, 1'b1);
    checkOutput("freeze after ack", 16'(freeze8), 16'h0);
    checkOutput("vector_oe after ack", 16'(vecOe8), 16'h0);
    reqValid = 1'b0;
    @(negedge clk);

    $display("[TB] AEOI with auto-rotate id 5");
    initSingle(0, 8'h40, 8'h03);
    applyStimulus(0, 3'd5, 16'h0080);
    checkOutput("prio before AEOI", 16'(prio8), 16'h0007);
    reqValid = 1'b1; reqId = 4'd5;
    expectEvent(K_ISR, 16'h0020);
    intaSet(0, 1'b0);
    intaSet(0, 1'b1);
    expectEvent(K_VEC, 16'h0045);
    intaSet(0, 1'b0);
    expectEvent(K_EOI, 16'h0020);
    intaSet(0, 1'b1);
    checkOutput("prio after AEOI rotate", 16'(prio8), 16'h0005);
    reqValid = 1'b0;
    @(negedge clk);

    $display("[TB] specific/non-specific EOI and spurious acknowledge");
    initSingle(0, 8'h40, 8'h01);
    isr = 16'h0004;
    expectEvent(K_EOI, 16'h0004);
    applyStimulus(0, 3'd5, 16'h00E2);
    checkOutput("prio after rotate SEOI", 16'(prio8), 16'h0002);
    isr = 16'h0024;
    expectEvent(K_EOI, 16'h0020);
    applyStimulus(0, 3'd5, 16'h0020);
    isr = 16'h0003;
    expectEvent(K_EOI, 16'h0001);
    applyStimulus(0, 3'd5, 16'h00A0);
    checkOutput("prio after rotate NSEOI wrap", 16'(prio8), 16'h0000);
    isr = 16'h0000;
    applyStimulus(0, 3'd5, 16'h0020);
    expectEvent(K_VEC, 16'h0047);
    intaSet(0, 1'b0);
    intaSet(0, 1'b1);
    intaSet(0, 1'b0);
    intaSet(0, 1'b1);

    $display("[TB] ICW1 rewrite between INTA pulses");
    reqValid = 1'b1; reqId = 4'd3;
    expectEvent(K_ISR, 16'h0008);
    intaSet(0, 1'b0);
    intaSet(0, 1'b1);
    applyStimulus(0, 3'd0, 16'h0013);
    checkOutput("abort freeze", 16'(freeze8), 16'h0);
    checkOutput("abort imr", 16'(imr8), 16'h00FF);
    checkOutput("abort init_done", 16'(done8), 16'h0);
    intaSet(0, 1'b0);
    checkOutput("abort vector_oe", 16'(vecOe8), 16'h0);
    checkOutput("abort freeze low", 16'(freeze8), 16'h0);
    intaSet(0, 1'b1);
    applyStimulus(0, 3'd3, 16'h0001);
    checkOutput("ICW4 ignored in ICW2", 16'(done8), 16'h0);
    applyStimulus(0, 3'd1, 16'h0040);
    applyStimulus(0, 3'd3, 16'h0001);
    checkOutput("re-init done", 16'(done8), 16'h1);

    $display("[TB] read-back");
    irr = 16'h005A; rdSel = 2'd0;
    @(negedge clk);
    checkOutput("rd_data IRR", 16'(rdData8), 16'h005A);
    rdSel = 2'd3;
    @(negedge clk);
    checkOutput("rd_data sel3", 16'(rdData8), 16'h0000);

    $display("[TB] 16-line instance");
    initSingle(1, 8'h70, 8'h01);
    checkOutput("done16", 16'(done16), 16'h1);
    applyStimulus(1, 3'd4, 16'hF0F0);
    rdSel = 2'd2;
    repeat (2) @(negedge clk);
    checkOutput("rd_data16 IMR", rdData16, 16'hF0F0);
    reqValid = 1'b1; reqId = 4'd12;
    intaSet(1, 1'b0);
    checkOutput("isr_set16", isrSet16, 16'h1000);
    intaSet(1, 1'b1);
    intaSet(1, 1'b0);
    checkOutput("vector16", 16'(vector16), 16'h007C);
    checkOutput("vector_oe16", 16'(vecOe16), 16'h1);
    intaSet(1, 1'b1);
    reqValid = 1'b0;
    repeat (3) @(negedge clk);

    checkOutput("scoreboard drained", 16'(expQ.size()), 16'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
